// File: rtl/response_pkg.sv
// ---------------------------------------------------------------------------
// response_pkg
// Shared types and constants for the response checker: the FSM state
// encoding (also exported on the debug 'state' port), slot/digit widths,
// the saturation value of the two-digit BCD score and a saturating BCD
// increment helper.
// ---------------------------------------------------------------------------
package response_pkg;

    localparam int SLOT_W  = 2;
    localparam int DIGIT_W = 2;
    localparam int BCD_MAX = 99;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LOAD         = 3'd1,
        WAIT_PRESS   = 3'd2,
        CHECK        = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    // Returns {tens, ones} incremented by one, holding at BCD_MAX.
    function automatic logic [7:0] bcdIncSat(input logic [3:0] tens,
                                             input logic [3:0] ones);
        logic [7:0] result;
        result = {tens, ones};
        if (!((tens == 4'(BCD_MAX / 10)) && (ones == 4'(BCD_MAX % 10)))) begin
            if (ones == 4'd9) begin
                result = {tens + 4'd1, 4'd0};
            end else begin
                result = {tens, ones + 4'd1};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Two-flop synchronizer followed by a stable-level counter for an active-low
// push-button. A new level is accepted only after the synchronized input has
// differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports
//   i_clk        in   system clock
//   i_rst_n      in   asynchronous active-low reset
//   i_keyN       in   raw active-low key, asynchronous to i_clk
//   o_keyDown    out  debounced level, high while the key is held
//   o_pressEvent out  one-cycle pulse on an accepted released->pressed edge
// ---------------------------------------------------------------------------
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_keyN,
    output logic o_keyDown,
    output logic o_pressEvent
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_stableN;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_flush;
    logic             r_armed;
    logic             r_pressEvent;
    logic             w_accept;

    assign w_accept = (r_sync1 != r_stableN) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= i_keyN;
            r_sync1 <= r_sync0;
        end
    end

    // Any cycle where the synchronized level matches the accepted one
    // restarts the stability window, so short glitches never get through.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stableN <= 1'b1;
            r_cnt     <= '0;
        end else if (r_sync1 == r_stableN) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_stableN <= r_sync1;
            r_cnt     <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The synchronizer powers up reading "released" regardless of the real
    // key, so r_flush marks when it reflects the pin. Press events are only
    // armed once a genuine release has been seen; a key held through reset
    // must be let go before it can submit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flush      <= 2'b00;
            r_armed      <= 1'b0;
            r_pressEvent <= 1'b0;
        end else begin
            r_flush <= {r_flush[0], 1'b1};
            if (r_flush[1] && r_sync1 && r_stableN) begin
                r_armed <= 1'b1;
            end
            r_pressEvent <= w_accept && !r_sync1 && r_armed;
        end
    end

    assign o_keyDown    = !r_stableN;
    assign o_pressEvent = r_pressEvent;

endmodule

// File: rtl/response_checker.sv
// ---------------------------------------------------------------------------
// response_checker
// Three-digit guessing round. Targets are latched in LOAD; each debounced
// key press compares the switch guess against the target of the current
// slot, pulses hit or miss and updates a saturating BCD score. A held key
// resolves only one slot; the next slot is armed on debounced release.
//
// Optional feature: define RESPONSE_TIMEOUT_EN to resolve a slot as a miss
// after TIMEOUT_TICKS pulses of tick_1hz without a press.
//
// Ports
//   CLOCK_50               in   system clock
//   resetn                 in   asynchronous active-low reset
//   game_active            in   level, round play enabled while high
//   tick_1hz               in   one-cycle pulse per second (timeout only)
//   target0/1/2 [1:0]      in   challenge digits, 0..2
//   guess [1:0]            in   player value from switches
//   key_submit_n           in   raw active-low submit button
//   slot [1:0]             out  digit currently being answered
//   hit, miss              out  one-cycle result pulses
//   seq_done               out  one-cycle pulse after slot 2 resolves
//   score_ones/score_tens  out  BCD score 00..99
//   state [2:0]            out  FSM state, for debug
// ---------------------------------------------------------------------------
module response_checker
    import response_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_TICKS   = 5
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               game_active,
    input  logic               tick_1hz,
    input  logic [DIGIT_W-1:0] target0,
    input  logic [DIGIT_W-1:0] target1,
    input  logic [DIGIT_W-1:0] target2,
    input  logic [DIGIT_W-1:0] guess,
    input  logic               key_submit_n,
    output logic [SLOT_W-1:0]  slot,
    output logic               hit,
    output logic               miss,
    output logic               seq_done,
    output logic [3:0]         score_ones,
    output logic [3:0]         score_tens,
    output logic [2:0]         state
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(2);

    state_t             r_state;
    state_t             w_nextState;
    logic [SLOT_W-1:0]  r_slot;
    logic [DIGIT_W-1:0] r_target0;
    logic [DIGIT_W-1:0] r_target1;
    logic [DIGIT_W-1:0] r_target2;
    logic [3:0]         r_ones;
    logic [3:0]         r_tens;
    logic               r_hit;
    logic               r_miss;
    logic               r_seqDone;

    logic               w_keyDown;
    logic               w_submit;
    logic               w_timeout;
    logic               w_match;
    logic [DIGIT_W-1:0] w_curTarget;
    logic               w_hitNext;
    logic               w_missNext;
    logic               w_seqDoneNext;
    logic               w_slotAdvance;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_keyDebouncer (
        .i_clk       (CLOCK_50),
        .i_rst_n     (resetn),
        .i_keyN      (key_submit_n),
        .o_keyDown   (w_keyDown),
        .o_pressEvent(w_submit)
    );

`ifdef RESPONSE_TIMEOUT_EN
    localparam int TICK_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    logic [TICK_W-1:0] r_tickCnt;

    assign w_timeout = (r_state == WAIT_PRESS) && tick_1hz &&
                       (r_tickCnt == TICK_W'(TIMEOUT_TICKS - 1));

    // Counts only while waiting on a press; leaving WAIT_PRESS or advancing
    // the slot starts the next slot with a fresh budget.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_tickCnt <= '0;
        end else if ((w_nextState != WAIT_PRESS) || w_slotAdvance) begin
            r_tickCnt <= '0;
        end else if (tick_1hz) begin
            r_tickCnt <= r_tickCnt + TICK_W'(1);
        end
    end
`else
    logic w_unusedTick;
    assign w_unusedTick = tick_1hz & (TIMEOUT_TICKS != 0);
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        case (r_slot)
            2'd0:    w_curTarget = r_target0;
            2'd1:    w_curTarget = r_target1;
            default: w_curTarget = r_target2;
        endcase
    end

    // Guess 3 never matches, even if an illegal target 3 was latched.
    assign w_match = (guess != 2'd3) && (guess == w_curTarget);

    // Dropping game_active wins over everything, including a submit in the
    // same cycle, and suppresses all result pulses.
    always_comb begin
        w_nextState   = r_state;
        w_hitNext     = 1'b0;
        w_missNext    = 1'b0;
        w_seqDoneNext = 1'b0;
        w_slotAdvance = 1'b0;
        if (!game_active) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState = LOAD;
                end
                LOAD: begin
                    w_nextState = WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    if (w_submit) begin
                        w_nextState = CHECK;
                    end else if (w_timeout) begin
                        w_missNext    = 1'b1;
                        w_seqDoneNext = (r_slot == LAST_SLOT);
                        w_slotAdvance = 1'b1;
                        w_nextState   = (r_slot == LAST_SLOT) ? LOAD : WAIT_PRESS;
                    end
                end
                CHECK: begin
                    w_hitNext     = w_match;
                    w_missNext    = !w_match;
                    w_seqDoneNext = (r_slot == LAST_SLOT);
                    w_nextState   = WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!w_keyDown) begin
                        w_slotAdvance = 1'b1;
                        w_nextState   = (r_slot == LAST_SLOT) ? LOAD : WAIT_PRESS;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_seqDone <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_hit     <= w_hitNext;
            r_miss    <= w_missNext;
            r_seqDone <= w_seqDoneNext;
        end
    end

    // Slot holds the just-answered index through WAIT_RELEASE and moves on
    // when the key is let go (or immediately on a timeout miss).
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_slot <= '0;
        end else if ((w_nextState == IDLE) || (r_state == LOAD)) begin
            r_slot <= '0;
        end else if (w_slotAdvance) begin
            r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + SLOT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_target0 <= '0;
            r_target1 <= '0;
            r_target2 <= '0;
        end else if (r_state == LOAD) begin
            r_target0 <= target0;
            r_target1 <= target1;
            r_target2 <= target2;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_ones <= '0;
            r_tens <= '0;
        end else if (w_hitNext) begin
            {r_tens, r_ones} <= bcdIncSat(r_tens, r_ones);
        end
    end

    assign slot       = r_slot;
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign seq_done   = r_seqDone;
    assign score_ones = r_ones;
    assign score_tens = r_tens;
    assign state      = r_state;

endmodule

// File: doc/response_checker.md
RESPONSE_CHECKER -- requirements
Module: response_checker

Interface
REQ-001 One clock, CLOCK_50; reset is asynchronous and active-low, port resetn.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, cycles a raw key level must be stable to be accepted (20 ms at 50 MHz).
REQ-003 Parameter TIMEOUT_TICKS, default 5, one-second ticks allowed per slot when timeout is compiled in.
REQ-004 CLOCK_50  in  1  system clock.
REQ-005 resetn  in  1  async active-low reset.
REQ-006 game_active  in  1  level; high = round play enabled.
REQ-007 tick_1hz  in  1  single-cycle pulse once per second.
REQ-008 target0, target1, target2  in  2 each  challenge digits, legal values 0..2.
REQ-009 guess  in  2  player value from switches.
REQ-010 key_submit_n  in  1  raw push-button, active-low, asynchronous to CLOCK_50.
REQ-011 slot  out  2  index of the digit currently being answered (0..2).
REQ-012 hit, miss  out  1 each  single-cycle result pulses.
REQ-013 seq_done  out  1  single-cycle pulse after slot 2 resolves; requests new targets.
REQ-014 score_ones, score_tens  out  4 each  BCD score, 00..99.
REQ-015 state  out  3  FSM state encoding, for debug.

Function
REQ-016 key_submit_n passes a two-flop synchronizer, then the debouncer; a submit event is one cycle on the debounced released-to-pressed transition.
REQ-017 FSM states: IDLE, LOAD, WAIT_PRESS, CHECK, WAIT_RELEASE.
REQ-018 IDLE -> LOAD when game_active high; LOAD latches target0..2 into internal copies, slot=0, -> WAIT_PRESS next cycle.
REQ-019 WAIT_PRESS -> CHECK on submit event; CHECK compares guess to latched target[slot] in exactly one cycle.
REQ-020 Equal: hit pulses and score increments (BCD: ones 9 -> 0 with tens+1); unequal or guess==3: miss pulses, score unchanged.
REQ-021 Score saturates at 99; a hit at 99 still pulses hit.
REQ-022 CHECK -> WAIT_RELEASE; the next slot is accepted only after debounced release (no auto-repeat on a held key).
REQ-023 After slot 2 resolves, seq_done pulses with the hit/miss of that slot; slot returns to 0 and FSM re-enters LOAD on release.
REQ-024 Target input changes outside LOAD have no effect on the sequence.
REQ-025 game_active low in any state -> IDLE next cycle, slot=0, score held; no pulses issued.
REQ-026 Submit event coincident with game_active falling is ignored.

Reset
REQ-027 On resetn low: state=IDLE, slot=0, score=00, hit=miss=seq_done=0, synchronizer and debouncer at released, counters 0.
REQ-028 Reset mid-press: after release of resetn a still-held key produces no submit until released and pressed again.

Configuration
REQ-029 Macro RESPONSE_TIMEOUT_EN: when defined, WAIT_PRESS counts tick_1hz; at TIMEOUT_TICKS ticks the slot resolves as a miss (goes straight to slot advance, no release needed) and the count clears on every slot change.
REQ-030 Without RESPONSE_TIMEOUT_EN no tick counter exists and tick_1hz is unused.

Structure
REQ-031 Package response_pkg holds the FSM state enum, SLOT_W=2, DIGIT_W=2, BCD_MAX=99.
REQ-032 Sub-module key_debouncer (synchronizer + stable counter, parameter DEBOUNCE_CYCLES) is instantiated once.

Verification (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3)
REQ-033 Targets 1,2,0, guesses 1,2,0 with clean presses -> three hits, seq_done once, score 03.
REQ-034 Targets 2,2,2, guesses 2,0,3 -> hit,miss,miss, score 01.
REQ-035 Key bounces for 2-cycle glitches then held 10 cycles -> exactly one submit; held key through two slots -> only one slot resolved.
REQ-036 Preload score 99 via 99 hits, one more hit -> hit pulses, score stays 99; score 09 + hit -> 10.
REQ-037 With RESPONSE_TIMEOUT_EN, no press for 3 ticks -> miss on slot 0, slot=1, score unchanged.
REQ-038 resetn asserted during WAIT_RELEASE at score 05 -> state IDLE, score 00, no pulse.
